// File: rtl/factorial_seq.sv
// factorial_seq: FIFO-buffered request sequencer in front of the factorial_top core.
// Define FACT_SEQ_OVF_CHECK_EN to reject operands whose factorial overflows SIZE bits.
module factorial_seq #(
   parameter int unsigned SIZE    = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIZE-1:0]          in_n,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIZE-1:0]          out_result,
   output logic [SIZE-1:0]          out_n,
   output logic                     out_err,
   output logic                     core_go,
   output logic [SIZE-1:0]          core_n,
   input  logic                     core_done,
   input  logic [SIZE-1:0]          core_result,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;
   localparam int unsigned CW   = $clog2(TIMEOUT);

   localparam logic [CNTW-1:0] Full    = CNTW'(DEPTH);
   localparam logic [CW-1:0]   CntLast = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   Blank   = CW'(2);

`ifdef FACT_SEQ_OVF_CHECK_EN
   // Largest n with n! < 2^SIZE, evaluated at elaboration.
   function automatic int unsigned calc_nmax();
      logic [127:0] f;
      logic [127:0] lim;
      int unsigned  nm;
      logic         stop;
      f    = 128'd1;
      lim  = 128'd1 << SIZE;
      nm   = 0;
      stop = 1'b0;
      for (int unsigned i = 1; i < 64; i++) begin
         if (!stop) begin
            f = f * 128'(i);
            if (f < lim) nm = i;
            else         stop = 1'b1;
         end
      end
      return nm;
   endfunction

   localparam logic [SIZE-1:0] NMAX = SIZE'(calc_nmax());
`endif

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOut} state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [SIZE-1:0] op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] res_q, res_d;
   logic [SIZE-1:0] outn_q, outn_d;
   logic            err_q, err_d;
   logic            push, pop;
   logic [SIZE-1:0] head;

   assign in_ready   = (count_q < Full);
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q];
   assign out_valid  = (state_q == StOut);
   assign busy       = (state_q != StIdle);
   assign core_go    = (state_q == StLaunch);
   assign core_n     = op_q;
   assign fifo_count = count_q;
   assign out_result = res_q;
   assign out_n      = outn_q;
   assign out_err    = err_q;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      op_d    = op_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      outn_d  = outn_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop  = 1'b1;
               op_d = head;
`ifdef FACT_SEQ_OVF_CHECK_EN
               if (head > NMAX) begin
                  state_d = StOut;
                  res_d   = '0;
                  outn_d  = head;
                  err_d   = 1'b1;
               end else begin
                  state_d = StLaunch;
               end
`else
               state_d = StLaunch;
`endif
            end
         end
         StLaunch: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // The first two WAIT cycles mask a stale done from an abandoned run.
            if (cnt_q >= Blank && core_done) begin
               res_d   = core_result;
               outn_d  = op_q;
               err_d   = 1'b0;
               state_d = StOut;
            end else if (cnt_q == CntLast) begin
               res_d   = '0;
               outn_d  = op_q;
               err_d   = 1'b1;
               state_d = StOut;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StOut: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         outn_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         outn_q   <= outn_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_n;
   end

endmodule

// File: doc/factorial_seq.md
# factorial_seq

Request sequencer sitting directly upstream of the `factorial_top` core.
- Accepts operands over a valid/ready stream and buffers them in a small FIFO.
- Drives the core's `go`/`n` inputs one request at a time and captures `result` on `done`.
- Returns each result, tagged with its operand and an error flag, over a second valid/ready stream.
- Bounds every core run with a timeout so a hung core cannot stall the pipeline.

## Interface
Parameters:
- SIZE, 8, operand/result width; must equal the core's SIZE.
- DEPTH, 4, input FIFO entries; power of two, ≥2.
- TIMEOUT, 64, max cycles spent in WAIT before abort; ≥4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  FIFO can accept; equals fifo_count < DEPTH.
- in_n  in  SIZE  operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  SIZE  n! (low SIZE bits), or 0 on error.
- out_n  out  SIZE  operand this result belongs to.
- out_err  out  1  timeout or (macro) overflow.
- core_go  out  1  one-cycle start pulse to core.
- core_n  out  SIZE  operand to core.
- core_done  in  1  core done.
- core_result  in  SIZE  core result.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  clog2(DEPTH)+1  entries queued.

## Operation
- Reset values:
  - in_ready=1, out_valid=0, out_result=0, out_n=0, out_err=0.
  - core_go=0, core_n=0, busy=0, fifo_count=0.
  - FSM=IDLE, FIFO pointers=0, timeout counter=0.
- FIFO:
  - Push on in_valid&&in_ready.
  - Pop only in IDLE when non-empty.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - No push when full; no pop when empty.
- FSM states:
  - IDLE: if fifo_count>0, pop the head into the operand register and go to LAUNCH; otherwise stay.
  - LAUNCH: core_go=1 and core_n=operand for exactly one cycle, then go to WAIT; the timeout counter clears.
  - WAIT:
    - core_go=0 and core_n held stable.
    - core_done is ignored during the first 2 WAIT cycles (blanking for stale done).
    - The first cycle after that with core_done=1 registers out_result=core_result, out_n=operand, out_err=0, then go to OUT.
    - If the counter reaches TIMEOUT-1 with no qualifying done: out_result=0, out_err=1, go to OUT.
  - OUT: out_valid=1 with outputs stable; on out_ready go to IDLE with out_valid=0 the next cycle.
- The core must restart on every go pulse regardless of its prior state; the sequencer never issues go outside LAUNCH.
- Reset mid-operation:
  - All state returns to reset values and queued operands are discarded.
  - An in-flight core run is abandoned; its done is masked by IDLE and by the next WAIT's blanking.

## Timing
- Push at edge k: the entry is visible at k+1, popped at k+1 if IDLE, LAUNCH at k+2, WAIT from k+3.
- With core done at WAIT cycle d (d≥2), out_valid rises at cycle k+3+d+1.
- Minimum back-to-back issue interval is 4 cycles plus core latency plus the out handshake.
- out_valid holds until accepted; out_* do not change while out_valid=1.
- in_ready depends only on registered fifo_count (no combinational path from out_ready).

## Configuration
- FACT_SEQ_OVF_CHECK_EN defined:
  - An elaboration-time constant NMAX is the largest n with n! < 2^SIZE (SIZE=8 → NMAX=5).
  - In IDLE, a popped operand > NMAX goes directly to OUT with out_result=0, out_err=1, out_n=operand, and no core_go.
- Undefined: every operand is launched; out_result is the core's truncated low SIZE bits and out_err reflects only timeout.

## Test plan
- SIZE=8, push n=5, out_ready=1 → one core_go pulse, core_n=5 stable through WAIT; out_result=120, out_n=5, out_err=0.
- Push n=0 then n=1 → two results in order, both out_result=1, out_err=0.
- out_ready=0, push 6 operands back-to-back → first popped, 5th accepted, in_ready=0 with fifo_count=4; release out_ready → results emerge in push order.
- Push n=6:
  - with FACT_SEQ_OVF_CHECK_EN → out_err=1, out_result=0, core_go never asserted;
  - without → out_result=208 (720 mod 256), out_err=0.
- Core model holds core_done=0 → out_valid rises with out_err=1, out_result=0 exactly TIMEOUT cycles after WAIT entry; next queued operand then launches.
- Assert rst_n=0 for 1 cycle mid-WAIT with 3 entries queued → all outputs at reset values, fifo_count=0, no core_go until a new push.
